// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller in front of a 4-bit ALU.
// Accepts one op per request handshake and drives the ALU control and operand lines.
// Returns the captured ALU result on a response handshake.
// MUL is built from repeated ALU additions.
// Vectors are [0:N], bit 0 = MSB.
module alu_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [0:2] req_op,
  input  logic [0:3] req_a,
  input  logic [0:3] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [0:3] rsp_res,
  output logic       rsp_err,
  output logic       busy,
  output logic       alu_sub,
  output logic [0:1] alu_afs,
  output logic [0:3] alu_a,
  output logic [0:3] alu_b,
  input  logic [0:3] alu_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t     state;
  logic [0:2] op_q;
  logic [0:3] a_q;
  logic [0:3] b_q;
  logic [0:3] acc_q;
  logic [0:3] cnt_q;
  logic       op_illegal;

  // Opcodes 11x have no ALU mapping.
  assign op_illegal = op_q[0] & op_q[1];

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Sequencer state, latched request, MUL accumulator and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            if (req_op == 3'b101) begin
              acc_q <= '0;
              cnt_q <= req_b;
              state <= MUL;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          if (op_illegal) begin
            rsp_res <= '0;
            rsp_err <= 1'b1;
          end else begin
            rsp_res <= alu_res;
            rsp_err <= 1'b0;
          end
          state <= RESP;
        end
        MUL: begin
          // Each pass adds A into the accumulator through the ALU; carry is dropped.
          if (cnt_q != 4'd0) begin
            acc_q <= alu_res;
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_res   <= acc_q;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive: active only in EXEC (legal ops) and MUL, otherwise all zero.
  always_comb begin
    alu_sub = 1'b0;
    alu_afs = 2'b00;
    alu_a   = '0;
    alu_b   = '0;
    case (state)
      EXEC: begin
        if (!op_illegal) begin
          alu_a = a_q;
          alu_b = b_q;
          case (op_q)
            3'b000:  alu_afs = 2'b00;
            3'b001:  alu_afs = 2'b01;
            3'b010:  alu_afs = 2'b10;
            3'b011:  alu_afs = 2'b11;
            3'b100: begin
              alu_afs = 2'b11;
              alu_sub = 1'b1;
            end
            default: begin
              alu_a = '0;
              alu_b = '0;
            end
          endcase
        end
      end
      MUL: begin
        alu_a   = acc_q;
        alu_b   = a_q;
        alu_afs = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: behavioural ALU stub plus a transaction-level reference model.
// Directed cases and randomized ops are checked every cycle against that model.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [0:2] req_op = '0;
  logic [0:3] req_a = '0;
  logic [0:3] req_b = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [0:3] rsp_res;
  logic       rsp_err;
  logic       busy;
  logic       alu_sub;
  logic [0:1] alu_afs;
  logic [0:3] alu_a;
  logic [0:3] alu_b;
  logic [0:3] alu_res;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_err(rsp_err), .busy(busy),
    .alu_sub(alu_sub), .alu_afs(alu_afs), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res)
  );

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU
  always_comb begin
    alu_res = '0;
    case (alu_afs)
      2'b00: alu_res = alu_a ^ alu_b;
      2'b01: alu_res = alu_a & alu_b;
      2'b10: alu_res = alu_a | alu_b;
      default: alu_res = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
    endcase
  end

  function automatic logic [3:0] ref_res(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (op)
      3'd0: r = a ^ b;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a + b;
      3'd4: r = a - b;
      3'd5: r = a * b;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks one outstanding transaction by cycle count since accept.
  logic       seen_reset = 1'b0;
  logic       m_active = 1'b0;
  int         m_k = 0;
  int         m_lat = 0;
  logic [2:0] m_op = '0;
  logic [3:0] m_a = '0;
  logic [3:0] m_b = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      seen_reset = 1'b1;
      m_active   = 1'b0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active = 1'b1;
        m_op     = req_op;
        m_a      = req_a;
        m_b      = req_b;
        m_k      = 1;
        m_lat    = (req_op == 3'd5) ? int'(req_b) + 2 : 2;
      end
    end else if (m_k >= m_lat) begin
      if (rsp_ready) m_active = 1'b0;
    end else begin
      m_k++;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    logic [14:0] exp_v;
    logic [14:0] act_v;
    logic        e_rdy, e_busy, e_val, e_sub;
    logic [1:0]  e_afs;
    logic [3:0]  e_a, e_b;
    if (seen_reset) begin
      e_rdy = 1'b1; e_busy = 1'b0; e_val = 1'b0;
      e_sub = 1'b0; e_afs = 2'b00; e_a = '0; e_b = '0;
      if (m_active) begin
        e_rdy  = 1'b0;
        e_busy = 1'b1;
        if (m_k >= m_lat) begin
          e_val = 1'b1;
        end else if (m_op == 3'd5) begin
          e_afs = 2'b11;
          e_a   = m_a * 4'(m_k - 1);
          e_b   = m_a;
        end else if (m_op < 3'd5) begin
          e_afs = (m_op < 3'd3) ? m_op[1:0] : 2'b11;
          e_sub = (m_op == 3'd4);
          e_a   = m_a;
          e_b   = m_b;
        end
      end
      exp_v = {e_rdy, e_busy, e_val, e_sub, e_afs, e_a, e_b, 1'b0};
      act_v = {req_ready, busy, rsp_valid, alu_sub, alu_afs, alu_a, alu_b, 1'b0};
      check("cycle_ctl", 32'(act_v), 32'(exp_v));
      if (e_val) begin
        check("cycle_rsp", {27'd0, rsp_err, rsp_res},
              {27'd0, (m_op >= 3'd6), ref_res(m_op, m_a, m_b)});
      end
    end
  end

  // One transaction: request, wait for response, optional backpressure, handshake.
  task automatic run_op(input string name, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input int hold, input logic [3:0] exp_res, input logic exp_err, input int exp_lat);
    int lat;
    logic [3:0] held;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 3'($urandom); req_a = 4'($urandom); req_b = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no rsp_valid after %0d cycles", name, lat);
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, {27'd0, rsp_err, rsp_res}, {27'd0, exp_err, exp_res});
    held = rsp_res;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check({name, "_hold"}, {26'd0, req_ready, rsp_valid, rsp_err, rsp_res}, {26'd0, 1'b0, 1'b1, exp_err, held});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, "_done"}, {30'd0, rsp_valid, req_ready}, {30'd0, 1'b0, 1'b1});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", {18'd0, req_ready, busy, rsp_valid, rsp_err, rsp_res, alu_sub, alu_afs, alu_a, alu_b},
          {18'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0, 4'd0});
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add",  3'b011, 4'b0111, 4'b0011, 0, 4'b1010, 1'b0, 2);
    run_op("sub",  3'b100, 4'b0010, 4'b0101, 0, 4'b1101, 1'b0, 2);
    run_op("xor",  3'b000, 4'b1100, 4'b1010, 0, 4'b0110, 1'b0, 2);
    run_op("and",  3'b001, 4'b1100, 4'b1010, 0, 4'b1000, 1'b0, 2);
    run_op("or",   3'b010, 4'b1100, 4'b1010, 0, 4'b1110, 1'b0, 2);
    run_op("mul5", 3'b101, 4'b0011, 4'b0101, 0, 4'b1111, 1'b0, 7);
    run_op("mul3", 3'b101, 4'b0110, 4'b0011, 1, 4'b0010, 1'b0, 5);
    run_op("mul0", 3'b101, 4'b1011, 4'b0000, 0, 4'b0000, 1'b0, 2);
    run_op("ill6", 3'b110, 4'b1111, 4'b1111, 3, 4'b0000, 1'b1, 2);
    run_op("ill7", 3'b111, 4'b0101, 4'b0001, 0, 4'b0000, 1'b1, 2);
    run_op("addbp", 3'b011, 4'b1111, 4'b0001, 3, 4'b0000, 1'b0, 2);

    // Reset in the middle of a MUL (cnt=2 on the 4th cycle after accept)
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b101; req_a = 4'b0011; req_b = 4'b0101;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_mul_reset", {19'd0, busy, rsp_valid, rsp_err, rsp_res, alu_sub, alu_afs, alu_a, alu_b},
          {19'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 4'd0, 4'd0});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_op("add_after_rst", 3'b011, 4'b0111, 4'b0011, 0, 4'b1010, 1'b0, 2);

    // Randomized ops against the reference function
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [3:0] a, b;
      op = 3'($urandom);
      a  = 4'($urandom);
      b  = 4'($urandom);
      run_op("rand", op, a, b, int'($urandom_range(0, 2)), ref_res(op, a, b), (op >= 3'd6),
             (op == 3'd5) ? int'(b) + 2 : 2);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
